mmio_bridge: RTL
================

MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, data bus width; LED_W, default 16, LED register width; SCR_DEPTH, default 4096, scratch word count (power of 2); KBD_DEPTH, default 8, key FIFO depth (power of 2, >=2); NUM_TMR, default 3, timer channel count (1..64).
REQ-002 clock  in  1  single clock; all logic on posedge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 req_valid  in  1  request present; req_ready  out  1  request accepted when both high.
REQ-005 req_we  in  1  1=write, 0=read; req_addr  in  32  byte address; req_wdata  in  DATA_W  write data.
REQ-006 rsp_valid  out  1  one-cycle response strobe; rsp_rdata  out  DATA_W  read data; rsp_err  out  1  access error.
REQ-007 kbd_valid  in  1  key push strobe; kbd_code  in  8  key code.
REQ-008 led  out  LED_W  LED register.

Function
REQ-009 Region SHALL be req_addr[31:20] and offset req_addr[19:0]: 0x001 LED, 0x002 scratch (word index offset[19:2] mod SCR_DEPTH), 0x003 key FIFO, 0x004 timers (channel offset[7:2]), 0x00F error register; any other region is invalid.
REQ-010 FSM SHALL have states IDLE and RESP; req_ready=1 only in IDLE; accepted request moves IDLE->RESP; RESP->IDLE unconditionally after one cycle.
REQ-011 rsp_valid SHALL be high exactly in RESP, i.e. one cycle after acceptance; rsp_rdata/rsp_err valid only then, rsp_rdata=0 for writes.
REQ-012 Writes SHALL take effect on the accepting edge; reads SHALL sample state at the accepting edge.
REQ-013 LED: write loads req_wdata[LED_W-1:0]; read returns zero-extended led.
REQ-014 Scratch: full-width read/write word array, no reset of contents.
REQ-015 Key FIFO: offset 0x0 read pops head, returns {0,code}; offset 0x4 read returns {0, overflow, count}; write to offset 0x4 clears overflow; other FIFO writes invalid.
REQ-016 kbd_valid while full (and no same-cycle pop) SHALL drop the code and set sticky overflow.
REQ-017 Pop and push in same cycle: when full, push accepted; when empty, read returns 0 and push accepted.
REQ-018 Pop when empty SHALL return 0, leave FIFO unchanged, flag error.
REQ-019 Timer channel n: read returns count[n]; write loads pre[n]=req_wdata and clears count[n] and divider[n].
REQ-020 Divider[n] increments each cycle; when divider[n]==pre[n], divider clears and count[n] increments; pre=0 increments every cycle; count wraps 2^DATA_W-1 -> 0.
REQ-021 Channel index >= NUM_TMR SHALL be an error; read returns 0, write ignored.

Reset
REQ-022 On reset: FSM IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, led=0, FIFO empty, overflow=0, all pre/count/divider=0, error register=0.
REQ-023 Reset during RESP SHALL drop the pending response; no rsp_valid on the following cycle.

Configuration
REQ-024 Macro MMIO_BRIDGE_ERR_EN defined: error register present; bit0 invalid region, bit1 empty pop, bit2 bad timer channel, bit3 invalid FIFO write; bits sticky; region 0x00F read returns it, write clears it; rsp_err=1 on the errored access.
REQ-025 Macro undefined: no error register, rsp_err tied 0, region 0x00F treated as invalid (read 0, write ignored).

Verification
REQ-026 Write 0x0010_0000 data 0xABCD_1234 -> led=0x1234 next cycle; read same addr -> rsp_rdata=0x0000_1234, one cycle after acceptance.
REQ-027 Push 9 codes 0x10..0x18 with KBD_DEPTH=8 -> status reads count=8, overflow=1; eight pops return 0x10..0x17; ninth pop returns 0, rsp_err=1 (ERR_EN).
REQ-028 FIFO full, same-cycle pop and kbd_valid code 0x55 -> pop returns head, count stays 8, overflow stays 0, 0x55 returned last.
REQ-029 Write pre[1]=3 at 0x0040_0004, wait 40 cycles, read -> count[1]=10; read of channel 5 with NUM_TMR=3 -> 0, err bit2 set.
REQ-030 Read 0x0050_0000 -> rsp_err=1, error register=0x1 with ERR_EN; rsp_err=0, rdata=0 without.
REQ-031 Assert reset in RESP cycle -> rsp_valid=0 next cycle, led=0, req_ready=1.

Source files
------------

// File: rtl/mmio_bridge.sv
// Single-port memory-mapped bridge: LED register, scratch RAM, key FIFO and timer bank.
// Define MMIO_BRIDGE_ERR_EN to add the sticky error register at region 0x00F and drive rsp_err.
module mmio_bridge #(
    parameter int DATA_W    = 32,
    parameter int LED_W     = 16,
    parameter int SCR_DEPTH = 4096,
    parameter int KBD_DEPTH = 8,
    parameter int NUM_TMR   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              kbd_valid,
    input  logic [7:0]        kbd_code,
    output logic [LED_W-1:0]  led
);

    localparam int SCR_AW = $clog2(SCR_DEPTH);
    localparam int KBD_AW = $clog2(KBD_DEPTH);
    localparam int KBD_CW = KBD_AW + 1;

    typedef enum logic {IDLE, RESP} state_t;

    state_t state_reg, state_next;

    logic [11:0] region;
    logic [19:0] offset;
    logic        accept;
    logic        sel_led, sel_scr, sel_kbd, sel_tmr, sel_inv;

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign region  = req_addr[31:20];
    assign offset  = req_addr[19:0];
    assign sel_led = (region == 12'h001);
    assign sel_scr = (region == 12'h002);
    assign sel_kbd = (region == 12'h003);
    assign sel_tmr = (region == 12'h004);

`ifdef MMIO_BRIDGE_ERR_EN
    logic sel_err;
    assign sel_err = (region == 12'h00F);
    assign sel_inv = !(sel_led || sel_scr || sel_kbd || sel_tmr || sel_err);
`else
    assign sel_inv = !(sel_led || sel_scr || sel_kbd || sel_tmr);
`endif

    // ------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------
    logic [LED_W-1:0] led_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            led_reg <= '0;
        end else if (accept && sel_led && req_we) begin
            led_reg <= req_wdata[LED_W-1:0];
        end
    end

    assign led = led_reg;

    // ------------------------------------------------------------------
    // Scratch RAM: contents are never reset, read data is registered
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] scr_mem [SCR_DEPTH];
    logic [DATA_W-1:0] scr_rd_reg;
    logic [SCR_AW-1:0] scr_idx;

    assign scr_idx = req_addr[SCR_AW+1:2];

    always_ff @(posedge clock) begin
        if (accept && sel_scr) begin
            if (req_we) begin
                scr_mem[scr_idx] <= req_wdata;
            end else begin
                scr_rd_reg <= scr_mem[scr_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Key FIFO
    // ------------------------------------------------------------------
    logic [7:0]        kbd_mem [KBD_DEPTH];
    logic [KBD_AW-1:0] kbd_rd_ptr_reg, kbd_wr_ptr_reg;
    logic [KBD_CW-1:0] kbd_count_reg;
    logic              kbd_ovf_reg;
    logic              kbd_full, kbd_empty;
    logic              kbd_data_rd, kbd_pop, kbd_push, kbd_drop, kbd_stat_wr;

    assign kbd_full    = (kbd_count_reg == KBD_CW'(KBD_DEPTH));
    assign kbd_empty   = (kbd_count_reg == '0);
    assign kbd_data_rd = accept && sel_kbd && !req_we && (offset == 20'h0);
    assign kbd_pop     = kbd_data_rd && !kbd_empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO is still taken.
    assign kbd_push    = kbd_valid && (!kbd_full || kbd_pop);
    assign kbd_drop    = kbd_valid && kbd_full && !kbd_pop;
    assign kbd_stat_wr = accept && sel_kbd && req_we && (offset == 20'h4);

    always_ff @(posedge clock) begin
        if (kbd_push) begin
            kbd_mem[kbd_wr_ptr_reg] <= kbd_code;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            kbd_rd_ptr_reg <= '0;
            kbd_wr_ptr_reg <= '0;
            kbd_count_reg  <= '0;
            kbd_ovf_reg    <= 1'b0;
        end else begin
            if (kbd_push) begin
                kbd_wr_ptr_reg <= kbd_wr_ptr_reg + KBD_AW'(1);
            end
            if (kbd_pop) begin
                kbd_rd_ptr_reg <= kbd_rd_ptr_reg + KBD_AW'(1);
            end
            case ({kbd_push, kbd_pop})
                2'b10:   kbd_count_reg <= kbd_count_reg + KBD_CW'(1);
                2'b01:   kbd_count_reg <= kbd_count_reg - KBD_CW'(1);
                default: kbd_count_reg <= kbd_count_reg;
            endcase
            if (kbd_drop) begin
                kbd_ovf_reg <= 1'b1;
            end else if (kbd_stat_wr) begin
                kbd_ovf_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Timer bank
    // ------------------------------------------------------------------
    logic [5:0]                     tmr_ch;
    logic                           tmr_wr;
    logic [NUM_TMR-1:0][DATA_W-1:0] tmr_cnt;
    logic [DATA_W-1:0]              tmr_rdata;

    assign tmr_ch = offset[7:2];
    assign tmr_wr = accept && sel_tmr && req_we;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TMR; gi++) begin : g_tmr
            logic [DATA_W-1:0] pre_reg, cnt_reg, div_reg;
            logic              wr_hit;

            assign wr_hit = tmr_wr && (tmr_ch == 6'(gi));

            always_ff @(posedge clock) begin
                if (reset) begin
                    pre_reg <= '0;
                    cnt_reg <= '0;
                    div_reg <= '0;
                end else if (wr_hit) begin
                    pre_reg <= req_wdata;
                    cnt_reg <= '0;
                    div_reg <= '0;
                end else if (div_reg == pre_reg) begin
                    div_reg <= '0;
                    cnt_reg <= cnt_reg + DATA_W'(1);
                end else begin
                    div_reg <= div_reg + DATA_W'(1);
                end
            end

            assign tmr_cnt[gi] = cnt_reg;
        end
    endgenerate

    // Channels beyond NUM_TMR fall through the loop and read as zero.
    always_comb begin
        tmr_rdata = '0;
        for (int i = 0; i < NUM_TMR; i++) begin
            if (tmr_ch == 6'(i)) begin
                tmr_rdata = tmr_cnt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Error register
    // ------------------------------------------------------------------
`ifdef MMIO_BRIDGE_ERR_EN
    logic [3:0] err_reg;
    logic [3:0] err_bits;
    logic       tmr_bad;

    assign tmr_bad     = ({1'b0, tmr_ch} >= 7'(NUM_TMR));
    assign err_bits[0] = sel_inv;
    assign err_bits[1] = sel_kbd && !req_we && (offset == 20'h0) && kbd_empty;
    assign err_bits[2] = sel_tmr && tmr_bad;
    assign err_bits[3] = sel_kbd && req_we && (offset != 20'h4);

    always_ff @(posedge clock) begin
        if (reset) begin
            err_reg <= '0;
        end else if (accept) begin
            if (sel_err && req_we) begin
                err_reg <= '0;
            end else begin
                err_reg <= err_reg | err_bits;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read data select and response registers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_data_next;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_scr_reg;

    always_comb begin
        rd_data_next = '0;
        if (!req_we && !sel_inv) begin
            if (sel_led) begin
                rd_data_next = DATA_W'(led_reg);
            end else if (sel_kbd) begin
                if (offset == 20'h0) begin
                    rd_data_next = kbd_empty ? '0 : DATA_W'(kbd_mem[kbd_rd_ptr_reg]);
                end else if (offset == 20'h4) begin
                    rd_data_next = DATA_W'({kbd_ovf_reg, kbd_count_reg});
                end
            end else if (sel_tmr) begin
                rd_data_next = tmr_rdata;
            end
`ifdef MMIO_BRIDGE_ERR_EN
            else if (sel_err) begin
                rd_data_next = DATA_W'(err_reg);
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_rdata_reg <= '0;
            rsp_scr_reg   <= 1'b0;
        end else if (accept) begin
            rsp_rdata_reg <= rd_data_next;
            rsp_scr_reg   <= sel_scr && !req_we;
        end
    end

    // Scratch reads come straight from the RAM output register.
    assign rsp_rdata = rsp_scr_reg ? scr_rd_reg : rsp_rdata_reg;

`ifdef MMIO_BRIDGE_ERR_EN
    logic rsp_err_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_err_reg <= 1'b0;
        end else if (accept) begin
            rsp_err_reg <= |err_bits;
        end
    end

    assign rsp_err = rsp_err_reg;
`else
    assign rsp_err = 1'b0;
`endif

endmodule
